// File: rtl/esm_pkg.sv
// esm_pkg: shared types and constants for the issue buffer slice
package esm_pkg;
  typedef enum logic {S_IDLE, S_OFFER} issue_st_e;
  localparam logic [1:0] SETTLE = 2'd3;
  localparam int DEF_BS = 16;
  localparam int DEF_W = 32;
endpackage

// File: rtl/esm_rr_picker.sv
// esm_rr_picker: first set mask bit at or after i_ptr, wrapping around
module esm_rr_picker #(
  parameter int N = 16,
  localparam int B = $clog2(N)
) (
  input  logic [N-1:0] i_mask,
  input  logic [B-1:0] i_ptr,
  output logic         o_found,
  output logic [B-1:0] o_index
);
  always_comb begin
    o_found = 1'b0;
    o_index = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (i_mask[i_ptr + B'(k)]) begin
        o_found = 1'b1;
        o_index = i_ptr + B'(k);
      end
    end
  end
endmodule

// File: rtl/esm_issue_buffer.sv
// esm_issue_buffer: instruction buffer with settle delay and round-robin issue
module esm_issue_buffer
  import esm_pkg::*;
#(
  parameter int Instruction_word_size = DEF_W,
  parameter int bs = DEF_BS,
  localparam int BSB = $clog2(bs)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [Instruction_word_size-1:0] in_instr,
  input  logic                             in_regwrite,
  input  logic                             in_alusrc,
  output logic [BSB-1:0]                   core_index,
  output logic [Instruction_word_size-1:0] core_instr,
  output logic                             core_regwrite,
  output logic                             core_alusrc,
  output logic [0:bs-1]                    valid_entries,
  input  logic [0:bs-1]                    independent_instr,
  output logic                             issue_valid,
  input  logic                             issue_ready,
  output logic [BSB-1:0]                   issue_index,
  output logic [Instruction_word_size-1:0] issue_instr,
  input  logic                             flush,
  output logic [BSB:0]                     free_count
);
  logic [Instruction_word_size-1:0] r_mem [bs];
  logic [1:0]     r_settle [bs];
  logic [bs-1:0]  r_valid;
  logic [BSB:0]   r_free;
  logic [BSB-1:0] r_rr;
  issue_st_e      r_state;
  logic           w_accept, w_fire, w_alloc_found, w_pick_found;
  logic [BSB-1:0] w_alloc_idx, w_pick_idx;
  logic [bs-1:0]  w_elig, w_valid_nxt;
  logic [BSB:0]   w_used;

  esm_rr_picker #(.N(bs)) u_alloc (
    .i_mask(~r_valid), .i_ptr('0), .o_found(w_alloc_found), .o_index(w_alloc_idx)
  );
  esm_rr_picker #(.N(bs)) u_pick (
    .i_mask(w_elig), .i_ptr(r_rr), .o_found(w_pick_found), .o_index(w_pick_idx)
  );

  assign in_ready    = !rst && !flush && (r_free != '0);
  assign w_accept    = in_valid && in_ready && w_alloc_found;
  assign w_fire      = (r_state == S_OFFER) && issue_ready && !flush;
  assign issue_valid = (r_state == S_OFFER);
  assign free_count  = r_free;

  always_comb begin
    w_valid_nxt = r_valid;
    if (w_fire) w_valid_nxt[issue_index] = 1'b0;
    if (w_accept) w_valid_nxt[w_alloc_idx] = 1'b1;
    if (flush) w_valid_nxt = '0;
    w_used = '0;
    for (int i = 0; i < bs; i++) begin
      w_used = w_used + {{BSB{1'b0}}, w_valid_nxt[i]};
      w_elig[i] = r_valid[i] && (r_settle[i] == 2'd0) && independent_instr[i] && (r_state == S_IDLE);
      valid_entries[i] = r_valid[i];
    end
  end

  always_ff @(posedge clk)
    if (w_accept) r_mem[w_alloc_idx] <= in_instr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid       <= '0;
      r_free        <= (BSB+1)'(bs);
      r_rr          <= '0;
      r_state       <= S_IDLE;
      issue_index   <= '0;
      issue_instr   <= '0;
      core_index    <= '0;
      core_instr    <= '0;
      core_regwrite <= 1'b0;
      core_alusrc   <= 1'b0;
      for (int i = 0; i < bs; i++) r_settle[i] <= 2'd0;
    end else begin
      r_valid       <= w_valid_nxt;
      r_free        <= (BSB+1)'(bs) - w_used;
      core_instr    <= w_accept ? in_instr : '0;
      core_regwrite <= w_accept && in_regwrite;
      core_alusrc   <= w_accept && in_alusrc;
      if (w_accept) core_index <= w_alloc_idx;
      for (int i = 0; i < bs; i++)
        r_settle[i] <= flush ? 2'd0 :
                       (w_accept && w_alloc_idx == BSB'(i)) ? SETTLE :
                       (r_settle[i] != 2'd0) ? r_settle[i] - 2'd1 : 2'd0;
      if (flush) begin
        r_state <= S_IDLE;
        r_rr    <= '0;
      end else if (r_state == S_IDLE && w_pick_found) begin
        r_state     <= S_OFFER;
        issue_index <= w_pick_idx;
        issue_instr <= r_mem[w_pick_idx];
      end else if (w_fire) begin
        r_state <= S_IDLE;
        r_rr    <= issue_index + BSB'(1);
      end
    end
  end
endmodule
